// File: rtl/chunked_add_seq_pkg.sv
// Shared definitions for the chunked sequential adder.
//   CHUNK_W     : width of one core evaluation (4 bits)
//   state_t     : sequencer states IDLE / RUN / DONE
//   chunk_count : number of CHUNK_W slices in a given operand width
package chunked_add_seq_pkg;

  localparam int CHUNK_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int chunk_count(input int width);
    return width / CHUNK_W;
  endfunction

endpackage

// File: rtl/chunked_add_seq_adder.sv
// 4-bit Sklansky parallel-prefix adder core (purely combinational).
// Ports:
//   a, b  : 4-bit addends
//   cin   : carry into bit 0
//   sum   : a + b + cin, low 4 bits
//   cout  : carry out of bit 3
module adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic       g10, p10, g32, p32, g20, p20, g30, p30;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Level 1: pairwise group generate/propagate.
  assign g10 = g[1] | (p[1] & g[0]);
  assign p10 = p[1] & p[0];
  assign g32 = g[3] | (p[3] & g[2]);
  assign p32 = p[3] & p[2];

  // Level 2: Sklansky fan-out of the low group into bits 2 and 3.
  assign g20 = g[2] | (p[2] & g10);
  assign p20 = p[2] & p10;
  assign g30 = g32  | (p32 & g10);
  assign p30 = p32  & p10;

  // cin folds in as a generate entering below bit 0.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g10  | (p10  & cin);
  assign c[3] = g20  | (p20  & cin);
  assign c[4] = g30  | (p30  & cin);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];

endmodule

// File: rtl/chunked_add_seq.sv
// Sequential WIDTH-bit adder that reuses one 4-bit prefix adder core,
// processing one chunk per clock from the LSB chunk upward.
// Optional feature macro: CHUNKED_ADD_SEQ_SUB_EN (adds in_sub for A - B).
// Ports:
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   in_valid / in_ready : operand handshake; in_ready is high only in IDLE
//   in_a, in_b, in_cin  : operands and carry-in, captured at acceptance
//   in_sub              : (macro only) subtract instead of add
//   out_valid/out_ready : result handshake; result held while not taken
//   out_sum, out_cout   : WIDTH-bit result and carry out of the MSB chunk
//   busy                : high while in RUN or DONE
module chunked_add_seq
  import chunked_add_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef CHUNKED_ADD_SEQ_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int NCHUNK = chunk_count(WIDTH);
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (((WIDTH % CHUNK_W) != 0) || (WIDTH < CHUNK_W)) begin : g_bad_width
    $error("chunked_add_seq: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;

  logic               accept;
  logic               last;
  logic [CHUNK_W-1:0] core_a, core_b, core_sum;
  logic               core_cout;

  assign accept = in_valid && (state_q == IDLE);
  assign last   = (idx_q == IDX_W'(NCHUNK - 1));

  assign core_a = a_q[CHUNK_W*int'(idx_q) +: CHUNK_W];
  assign core_b = b_q[CHUNK_W*int'(idx_q) +: CHUNK_W];

  adder u_core (
    .a    (core_a),
    .b    (core_b),
    .cin  (carry_q),
    .sum  (core_sum),
    .cout (core_cout)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Control and result registers; the result is cleared on reset so an
  // aborted transaction never leaves a partial sum visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        idx_q <= '0;
`ifdef CHUNKED_ADD_SEQ_SUB_EN
        // Two's-complement subtract: ~B plus an initial carry of one.
        carry_q <= in_sub ? 1'b1 : in_cin;
`else
        carry_q <= in_cin;
`endif
      end else if (state_q == RUN) begin
        sum_q[CHUNK_W*int'(idx_q) +: CHUNK_W] <= core_sum;
        carry_q <= core_cout;
        idx_q   <= last ? '0 : idx_q + 1'b1;
        if (last) cout_q <= core_cout;
      end
    end
  end

  // Operand capture at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= in_a;
`ifdef CHUNKED_ADD_SEQ_SUB_EN
      b_q <= in_sub ? ~in_b : in_b;
`else
      b_q <= in_b;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

endmodule

// File: tb/tb_chunked_add_seq.sv
// Directed bench for chunked_add_seq at WIDTH = 4, 16 and 32, plus a
// random sweep checked against a plain a + b + cin model.
module tb_chunked_add_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a_bus, b_bus;
  logic        cin_bus;
  logic        out_ready;
`ifdef CHUNKED_ADD_SEQ_SUB_EN
  logic        sub_bus;
`endif

  logic        v4, v16, v32;
  logic        ir4, ir16, ir32;
  logic        ov4, ov16, ov32;
  logic        oc4, oc16, oc32;
  logic        bz4, bz16, bz32;
  logic [3:0]  os4;
  logic [15:0] os16;
  logic [31:0] os32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chunked_add_seq #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(ir4),
    .in_a(a_bus[3:0]), .in_b(b_bus[3:0]), .in_cin(cin_bus),
`ifdef CHUNKED_ADD_SEQ_SUB_EN
    .in_sub(sub_bus),
`endif
    .out_valid(ov4), .out_ready(out_ready), .out_sum(os4), .out_cout(oc4), .busy(bz4)
  );

  chunked_add_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(ir16),
    .in_a(a_bus[15:0]), .in_b(b_bus[15:0]), .in_cin(cin_bus),
`ifdef CHUNKED_ADD_SEQ_SUB_EN
    .in_sub(sub_bus),
`endif
    .out_valid(ov16), .out_ready(out_ready), .out_sum(os16), .out_cout(oc16), .busy(bz16)
  );

  chunked_add_seq #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(ir32),
    .in_a(a_bus), .in_b(b_bus), .in_cin(cin_bus),
`ifdef CHUNKED_ADD_SEQ_SUB_EN
    .in_sub(sub_bus),
`endif
    .out_valid(ov32), .out_ready(out_ready), .out_sum(os32), .out_cout(oc32), .busy(bz32)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] f_sum(input int w);
    case (w)
      4:       return {28'b0, os4};
      16:      return {16'b0, os16};
      default: return os32;
    endcase
  endfunction

  function automatic logic f_ov(input int w);
    case (w)
      4:       return ov4;
      16:      return ov16;
      default: return ov32;
    endcase
  endfunction

  function automatic logic f_oc(input int w);
    case (w)
      4:       return oc4;
      16:      return oc16;
      default: return oc32;
    endcase
  endfunction

  function automatic logic f_ir(input int w);
    case (w)
      4:       return ir4;
      16:      return ir16;
      default: return ir32;
    endcase
  endfunction

  function automatic logic f_bz(input int w);
    case (w)
      4:       return bz4;
      16:      return bz16;
      default: return bz32;
    endcase
  endfunction

  task automatic set_valid(input int w, input logic v);
    case (w)
      4:       v4  = v;
      16:      v16 = v;
      default: v32 = v;
    endcase
  endtask

  // Present one operand set, let it be accepted, then scramble the inputs so
  // any failure to capture at acceptance shows up in the result.
  task automatic start(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic c, input logic s);
    @(negedge clk);
    a_bus   = a;
    b_bus   = b;
    cin_bus = c;
`ifdef CHUNKED_ADD_SEQ_SUB_EN
    sub_bus = s;
`endif
    set_valid(w, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_valid(w, 1'b0);
    a_bus   = $urandom;
    b_bus   = $urandom;
    cin_bus = ~c;
`ifdef CHUNKED_ADD_SEQ_SUB_EN
    sub_bus = ~s;
`endif
  endtask

  // Wait (bounded) for out_valid after the accepting edge; returns run edges.
  task automatic wait_valid(input int w, output int cycles);
    cycles = 0;
    while (!f_ov(w) && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic do_add(input string tag, input int w, input logic [31:0] a,
                        input logic [31:0] b, input logic c, input logic s,
                        input logic [31:0] exp_sum, input logic exp_cout);
    int cyc;
    start(w, a, b, c, s);
    wait_valid(w, cyc);
    chk({tag, ".latency"}, 64'(cyc), 64'(w / 4));
    chk({tag, ".sum"},     64'(f_sum(w)), 64'(exp_sum));
    chk({tag, ".cout"},    64'(f_oc(w)),  64'(exp_cout));
    chk({tag, ".in_ready_done"}, 64'(f_ir(w)), 64'd0);
    chk({tag, ".busy_done"},     64'(f_bz(w)), 64'd1);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".valid_after"},    64'(f_ov(w)), 64'd0);
    chk({tag, ".in_ready_after"}, 64'(f_ir(w)), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    logic        seen;
    logic [31:0] ra, rb;
    logic        rc;
    logic [32:0] tot;

    rst = 1'b1; out_ready = 1'b0; a_bus = '0; b_bus = '0; cin_bus = 1'b0;
    v4 = 1'b0; v16 = 1'b0; v32 = 1'b0;
`ifdef CHUNKED_ADD_SEQ_SUB_EN
    sub_bus = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("reset.out_valid", 64'(ov16), 64'd0);
    chk("reset.out_sum",   64'(os16), 64'd0);
    chk("reset.out_cout",  64'(oc16), 64'd0);
    chk("reset.busy",      64'(bz16), 64'd0);
    chk("reset.in_ready",  64'(ir16), 64'd1);
    chk("reset.in_ready4", 64'(ir4),  64'd1);
    chk("reset.in_ready32",64'(ir32), 64'd1);

    // Directed 16-bit cases.
    do_add("ffff_p1", 16, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1);
    do_add("zero_c1", 16, 32'h0000, 32'h0000, 1'b1, 1'b0, 32'h0001, 1'b0);
    do_add("mixed",   16, 32'h1234, 32'h4321, 1'b0, 1'b0, 32'h5555, 1'b0);

    // Backpressure: result held, new in_valid ignored.
    start(16, 32'h8000, 32'h8000, 1'b1, 1'b0);
    wait_valid(16, cyc);
    chk("bp.latency", 64'(cyc), 64'd4);
    @(negedge clk);
    a_bus = 32'h1111; b_bus = 32'h2222; cin_bus = 1'b0;
    v16 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp.valid",    64'(ov16), 64'd1);
      chk("bp.sum",      64'(os16), 64'h0001);
      chk("bp.cout",     64'(oc16), 64'd1);
      chk("bp.in_ready", 64'(ir16), 64'd0);
      chk("bp.busy",     64'(bz16), 64'd1);
    end
    out_ready = 1'b1;
    v16 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp.in_ready_after", 64'(ir16), 64'd1);
    chk("bp.valid_after",    64'(ov16), 64'd0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ov16 || bz16) seen = 1'b1;
    end
    chk("bp.ignored_input", 64'(seen), 64'd0);

    // Reset after two run edges aborts the transaction.
    start(16, 32'h1111, 32'h2222, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_run.out_valid", 64'(ov16), 64'd0);
    chk("rst_run.out_sum",   64'(os16), 64'd0);
    chk("rst_run.in_ready",  64'(ir16), 64'd1);
    chk("rst_run.busy",      64'(bz16), 64'd0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (ov16) seen = 1'b1;
    end
    chk("rst_run.no_result", 64'(seen), 64'd0);
    do_add("after_rst", 16, 32'h00FF, 32'h0001, 1'b0, 1'b0, 32'h0100, 1'b0);

    // Narrowest and widest builds.
    do_add("w4",      4,  32'hF, 32'h1, 1'b1, 1'b0, 32'h1, 1'b1);
    do_add("w4_zero", 4,  32'h7, 32'h8, 1'b0, 1'b0, 32'hF, 1'b0);
    do_add("w32_max", 32, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    do_add("w32_mix", 32, 32'h1234_5678, 32'h8765_4321, 1'b0, 1'b0, 32'h9999_9999, 1'b0);

`ifdef CHUNKED_ADD_SEQ_SUB_EN
    do_add("sub_neg", 16, 32'h0005, 32'h0007, 1'b0, 1'b1, 32'hFFFE, 1'b0);
    do_add("sub_pos", 16, 32'h0007, 32'h0005, 1'b1, 1'b1, 32'h0002, 1'b1);
`endif

    // Random sweep against the a + b + cin model.
    for (int i = 0; i < 1000; i++) begin
      ra  = $urandom & 32'hFFFF;
      rb  = $urandom & 32'hFFFF;
      rc  = 1'($urandom_range(0, 1));
      tot = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
      do_add("rnd16", 16, ra, rb, rc, 1'b0, tot[31:0] & 32'hFFFF, tot[16]);
    end
    for (int i = 0; i < 1000; i++) begin
      ra  = $urandom;
      rb  = $urandom;
      rc  = 1'($urandom_range(0, 1));
      tot = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
      do_add("rnd32", 32, ra, rb, rc, 1'b0, tot[31:0], tot[32]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chunked_add_seq.md
Name: chunked_add_seq

Overview:
- Sequencer that computes WIDTH-bit additions by time-multiplexing the team's 4-bit Sklansky prefix adder core (module adder).
- Processes one 4-bit chunk per clock, LSB chunk first, and ripples the carry between chunks through a register.
- Uses a valid/ready handshake on both input and output.
- Sits between operand producers and consumers where area is preferred over single-cycle wide adders.

Parameters:
- WIDTH, 16, operand and sum width in bits. Must be a multiple of 4 and at least 4. Any other value is an elaboration error.
- NCHUNK, WIDTH/4, number of 4-bit chunks. Derived; not overridable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operands presented.
- in_ready  out  1  block can accept operands.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in to the LSB chunk.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_sum  out  WIDTH  in_a + in_b + in_cin, modulo 2^WIDTH.
- out_cout  out  1  carry out of the MSB chunk.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state = IDLE, chunk index = 0, carry register = 0.
  - out_valid = 0, out_sum = 0, out_cout = 0, busy = 0, in_ready = 1 on the following cycle.
  - Reset wins over all other events.
  - Reset during RUN or DONE aborts the transaction with no output; the aborted result is never presented.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid & in_ready: latch in_a, in_b into operand registers, carry register = in_cin, index = 0, go to RUN.
- RUN:
  - in_ready = 0.
  - Each edge: drive core a/b with chunk [4*index +: 4] and core cin with the carry register.
  - Write core sum into the result register bits [4*index +: 4], write carry register = core cout, index++.
  - On the edge that processes index NCHUNK-1: out_cout = core cout, go to DONE.
- DONE:
  - out_valid = 1, in_ready = 0.
  - out_sum and out_cout hold stable while out_ready = 0, for any number of cycles.
  - On an edge with out_ready = 1: out_valid = 0, go to IDLE.
  - out_sum and out_cout keep their last value until they are next overwritten.
- Latency:
  - The accepting edge is E0. out_valid is first high after edge E0+NCHUNK; for WIDTH=4 that is after E0+1.
  - Minimum issue interval is NCHUNK+2 cycles: accept, NCHUNK run cycles, handshake-out cycle, then IDLE.
- in_ready is combinationally (state==IDLE) and does not depend on in_valid. Inputs are ignored whenever in_ready = 0.
- Operands are captured at acceptance. Input changes after acceptance do not affect the result.
- Arithmetic: unsigned. The result is truncated to WIDTH, with the carry reported only on out_cout.
- The core is purely combinational; no chunk path spans more than one core evaluation.

Optional Feature:
- Macro: CHUNKED_ADD_SEQ_SUB_EN.
- Defined:
  - Adds port in_sub (in, 1), sampled at acceptance.
  - When in_sub = 1, the B operand register stores ~in_b and the carry register starts at 1, ignoring in_cin.
  - out_sum = in_a - in_b mod 2^WIDTH; out_cout = 1 means no borrow.
  - When in_sub = 0, behaviour is identical to the undefined case.
- Undefined: no in_sub port; add only.

Decomposition:
- Package chunked_add_seq_pkg holds:
  - CHUNK_W = 4.
  - Enum state_t {IDLE, RUN, DONE}, 2 bits.
  - Function chunk_count(width) returning width/CHUNK_W.
- One sub-module, the existing 4-bit prefix adder core (module adder), instantiated once. No other sub-modules.
- Index counter width is $clog2(NCHUNK), minimum 1.

Test Plan:
- WIDTH=16, A=0xFFFF, B=0x0001, cin=0 -> after 4 run edges: out_valid=1, out_sum=0x0000, out_cout=1 (carry crosses all chunk boundaries).
- A=0x0000, B=0x0000, cin=1 -> out_sum=0x0001, out_cout=0. Then A=0x1234, B=0x4321, cin=0 -> 0x5555, cout 0.
- Backpressure: hold out_ready=0 for 6 cycles after out_valid -> out_sum and out_cout stable, in_ready=0, busy=1. A new in_valid during this window is ignored; after out_ready=1, in_ready=1 on the next cycle.
- Reset mid-RUN: assert rst after 2 run edges -> next cycle out_valid=0, out_sum=0, in_ready=1, busy=0. A following transaction 0x00FF+0x0001 gives 0x0100.
- WIDTH=4 build: 0xF+0x1, cin=1 -> out_sum=0x1, out_cout=1 after 1 run edge. Add 1000 random operand pairs at WIDTH=16 and WIDTH=32 checked against a golden a+b+cin model.
- With CHUNKED_ADD_SEQ_SUB_EN: in_sub=1, A=0x0005, B=0x0007 -> out_sum=0xFFFE, out_cout=0. A=0x0007, B=0x0005 -> 0x0002, out_cout=1.
